// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for a downstream 4:1 mux: walks the enabled
// channels, holds each select for DWELL_CYCLES, and captures the mux output.
module mux_scan_ctrl #(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       continuous_i,
  input  logic [3:0] chan_en_i,
  input  logic       mux_data_i,
  output logic       sel0_o,
  output logic       sel1_o,
  output logic [3:0] sample_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_reg;
  logic [1:0]       sel_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       mask_reg;
  logic [3:0]       sample_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [3:0]       above_mask;
  logic [1:0]       next_idx;
  logic [1:0]       first_idx;
  logic             has_next;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  // Enabled channels strictly above the current select; the lowest of these is next.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_above
      assign above_mask[gi] = mask_reg[gi] && (2'(gi) > sel_reg);
    end
  endgenerate

  assign has_next  = |above_mask;
  assign next_idx  = lowest_set(above_mask);
  assign first_idx = lowest_set(chan_en_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg  <= IDLE;
      sel_reg    <= 2'd0;
      cnt_reg    <= '0;
      mask_reg   <= 4'd0;
      sample_reg <= 4'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i && (|chan_en_i)) begin
            mask_reg  <= chan_en_i;
            sel_reg   <= first_idx;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= DWELL;
          end
        end
        DWELL: begin
          if (cnt_reg == LAST_CNT) begin
            sample_reg[sel_reg] <= mux_data_i;
            cnt_reg             <= '0;
            if (has_next) begin
              sel_reg <= next_idx;
            end else begin
              done_reg <= 1'b1;
              // End of scan: a continuous wrap re-reads the live mask; sel is
              // left untouched when the scan stops.
              if (continuous_i) begin
                mask_reg <= chan_en_i;
              end
              if (continuous_i && (|chan_en_i)) begin
                sel_reg <= first_idx;
              end else begin
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign sel0_o   = sel_reg[0];
  assign sel1_o   = sel_reg[1];
  assign sample_o = sample_reg;
  assign busy_o   = busy_reg;
  assign done_o   = done_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: one DWELL_CYCLES=4 instance and one
// DWELL_CYCLES=1 instance, each feeding its own behavioural 4:1 mux.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, cont4, start1, cont1;
  logic [3:0] en4, en1;
  logic [3:0] ch_vals;

  logic       sel0_4, sel1_4, busy4, done4, mux4;
  logic       sel0_1, sel1_1, busy1, done1, mux1;
  logic [3:0] sample4, sample1;

  assign mux4 = ch_vals[{sel1_4, sel0_4}];
  assign mux1 = ch_vals[{sel1_1, sel0_1}];

  mux_scan_ctrl #(.DWELL_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start4),
    .continuous_i (cont4),
    .chan_en_i    (en4),
    .mux_data_i   (mux4),
    .sel0_o       (sel0_4),
    .sel1_o       (sel1_4),
    .sample_o     (sample4),
    .busy_o       (busy4),
    .done_o       (done4)
  );

  mux_scan_ctrl #(.DWELL_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start1),
    .continuous_i (cont1),
    .chan_en_i    (en1),
    .mux_data_i   (mux1),
    .sel0_o       (sel0_1),
    .sel1_o       (sel1_1),
    .sample_o     (sample1),
    .busy_o       (busy1),
    .done_o       (done1)
  );

  typedef struct {
    logic [3:0] sample;
    logic       busy;
    int         cyc;
  } done_exp_t;

  logic [1:0] sel_q[2][$];
  done_exp_t  done_q[2][$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_sel(input int id, input logic [1:0] s, input int reps);
    repeat (reps) sel_q[id].push_back(s);
  endtask

  task automatic push_done(input int id, input logic [3:0] smp, input logic b, input int c);
    done_exp_t d;
    d.sample = smp;
    d.busy   = b;
    d.cyc    = c;
    done_q[id].push_back(d);
  endtask

  // Monitor: every busy cycle consumes one expected select, every done pulse one scan result.
  task automatic mon_inst(input int id, input logic busy, input logic done,
                          input logic [1:0] sel, input logic [3:0] smp);
    logic [1:0] es;
    done_exp_t  d;
    if (busy === 1'b1) begin
      if (sel_q[id].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sel_extra[%0d]: busy with sel=%0d at cycle %0d, none expected", id, sel, cyc);
      end else begin
        es = sel_q[id].pop_front();
        check($sformatf("sel[%0d]", id), 32'(sel), 32'(es));
      end
    end
    if (done === 1'b1) begin
      if (done_q[id].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_extra[%0d]: done pulse at cycle %0d, none expected", id, cyc);
      end else begin
        d = done_q[id].pop_front();
        $display("[TB] inst %0d scan done at cycle %0d sample=%b busy=%b", id, cyc, smp, busy);
        check($sformatf("done_cyc[%0d]", id), 32'(cyc), 32'(d.cyc));
        check($sformatf("sample[%0d]", id), 32'(smp), 32'(d.sample));
        check($sformatf("busy_at_done[%0d]", id), 32'(busy), 32'(d.busy));
      end
    end
  endtask

  task automatic start_scan(input int id, input logic [3:0] en, input logic cont, output int c0);
    if (id == 0) begin
      start4 = 1'b1; en4 = en; cont4 = cont;
    end else begin
      start1 = 1'b1; en1 = en; cont1 = cont;
    end
    @(posedge clk);
    #1;
    if (id == 0) start4 = 1'b0;
    else         start1 = 1'b0;
    c0 = cyc;
    $display("[TB] inst %0d start mask=%b cont=%b at cycle %0d", id, en, cont, c0);
  endtask

  task automatic drain(input int id, input int bound);
    int n = 0;
    while ((sel_q[id].size() != 0 || done_q[id].size() != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (sel_q[id].size() != 0 || done_q[id].size() != 0) begin
      fails++;
      $display("FAIL drain[%0d]: %0d selections and %0d done pulses never arrived",
               id, sel_q[id].size(), done_q[id].size());
      sel_q[id].delete();
      done_q[id].delete();
    end
    #1;
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    start4 = 1'b0; cont4 = 1'b0; en4 = 4'd0;
    start1 = 1'b0; cont1 = 1'b0; en1 = 4'd0;
    ch_vals = 4'd0;

    fork
      forever begin
        @(negedge clk);
        mon_inst(0, busy4, done4, {sel1_4, sel0_4}, sample4);
        mon_inst(1, busy1, done1, {sel1_1, sel0_1}, sample1);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_sel", 32'({sel1_4, sel0_4}), 32'd0);
    check("rst_sample", 32'(sample4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);

    // Reset in the middle of a scan discards it.
    ch_vals = 4'b0001;
    start_scan(0, 4'b1111, 1'b0, c0);
    push_sel(0, 2'd0, 4);
    push_sel(0, 2'd1, 2);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_sample", 32'(sample4), 32'b0001);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_sel", 32'({sel1_4, sel0_4}), 32'd0);
    check("mid_rst_sample", 32'(sample4), 32'd0);
    check("mid_rst_busy", 32'(busy4), 32'd0);
    check("mid_rst_done", 32'(done4), 32'd0);
    repeat (20) @(posedge clk);
    drain(0, 2);

    // Full scan, inputs ch0..ch3 = 1,0,1,1.
    ch_vals = 4'b1101;
    start_scan(0, 4'b1111, 1'b0, c0);
    push_sel(0, 2'd0, 4); push_sel(0, 2'd1, 4); push_sel(0, 2'd2, 4); push_sel(0, 2'd3, 4);
    push_done(0, 4'b1101, 1'b0, c0 + 16);
    drain(0, 40);
    check("idle_sel_hold", 32'({sel1_4, sel0_4}), 32'd3);

    // Preload 0101, then sparse mask 1010 with start and mask changes mid-scan.
    ch_vals = 4'b0101;
    start_scan(0, 4'b1111, 1'b0, c0);
    push_sel(0, 2'd0, 4); push_sel(0, 2'd1, 4); push_sel(0, 2'd2, 4); push_sel(0, 2'd3, 4);
    push_done(0, 4'b0101, 1'b0, c0 + 16);
    drain(0, 40);
    ch_vals = 4'b0010;
    start_scan(0, 4'b1010, 1'b0, c0);
    push_sel(0, 2'd1, 4); push_sel(0, 2'd3, 4);
    push_done(0, 4'b0111, 1'b0, c0 + 8);
    repeat (2) @(posedge clk);
    #1;
    start4 = 1'b1;
    en4 = 4'b0001;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    drain(0, 30);

    // Continuous scan on mask 1001; continuous drops during the third pass.
    ch_vals = 4'b1000;
    start_scan(0, 4'b1001, 1'b1, c0);
    for (int k = 0; k < 3; k++) begin
      push_sel(0, 2'd0, 4);
      push_sel(0, 2'd3, 4);
    end
    push_done(0, 4'b1110, 1'b1, c0 + 8);
    push_done(0, 4'b1110, 1'b1, c0 + 16);
    push_done(0, 4'b1110, 1'b0, c0 + 24);
    repeat (17) @(posedge clk);
    #1;
    cont4 = 1'b0;
    drain(0, 40);

    // Start with an empty mask is ignored.
    start_scan(0, 4'b0000, 1'b0, c0);
    check("empty_start_busy", 32'(busy4), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("empty_start_busy_later", 32'(busy4), 32'd0);
    check("empty_start_sel", 32'({sel1_4, sel0_4}), 32'd3);
    check("empty_start_sample", 32'(sample4), 32'b1110);

    // DWELL_CYCLES=1 instance: select advances every cycle.
    ch_vals = 4'b0110;
    start_scan(1, 4'b1111, 1'b0, c0);
    push_sel(1, 2'd0, 1); push_sel(1, 2'd1, 1); push_sel(1, 2'd2, 1); push_sel(1, 2'd3, 1);
    push_done(1, 4'b0110, 1'b0, c0 + 4);
    drain(1, 20);
    repeat (4) @(posedge clk);
    #1;
    check("d1_idle_busy", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
